branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised dynamic branch predictor for the 5-stage RV32I pipeline. It replaces static predict-not-taken with a direct-mapped BTB plus per-entry saturating counters. The IF stage looks up the current PC combinationally to choose the next fetch address. The EX stage, where branch outcomes are resolved, trains the tables and accumulates prediction statistics.

## Interface
- ENTRIES, 16, number of BTB/counter entries; power of two, 2..256; IDX_W = log2(ENTRIES)
- TAG_W, 8, tag bits stored per entry; IDX_W+TAG_W+2 ≤ 32
- CNT_W, 2, saturating counter width, ≥1

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- lookup_pc  in  32  IF-stage PC to predict
- pred_hit  out  1  valid entry with matching tag at lookup_pc
- pred_taken  out  1  predict redirect
- pred_target  out  32  next fetch address
- upd_en  in  1  EX resolved a branch/jump this cycle
- upd_pc  in  32  PC of resolved instruction
- upd_taken  in  1  actual outcome
- upd_target  in  32  actual taken target
- upd_uncond  in  1  instruction is JAL (unconditional, PC-relative)
- upd_mispredict  in  1  EX detected misprediction (statistics only)
- clear  in  1  synchronous invalidate of all entries
- stat_branches  out  32  resolved-update count
- stat_mispredicts  out  32  mispredict count

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- Per entry: valid, tag, target[31:0], uncond, cnt[CNT_W-1:0].
- Lookup (combinational): pred_hit = valid[i] & tag match. pred_taken = pred_hit & (uncond[i] | cnt[i][MSB]). pred_target = pred_taken ? target[i] : lookup_pc+4 (mod 2^32).
- Update on upd_en (tag compared at upd index):
  - Hit: counter saturating +1 if upd_taken, −1 otherwise; target ← upd_target when upd_taken; uncond ← upd_uncond. Uncond entries hold cnt at max and ignore not-taken.
  - Miss and upd_taken: allocate/replace. valid=1, tag, target, uncond=upd_uncond; cnt = 2^(CNT_W-1) (weakly taken), or max if uncond.
  - Miss and not taken: no table change.
- Statistics on upd_en: stat_branches +1; stat_mispredicts +1 when upd_mispredict. Both saturate at 0xFFFF_FFFF, never wrap.
- clear: all valid←0, cnt←2^(CNT_W-1)−1. Targets, tags and statistics unchanged. clear has priority over upd_en in the same cycle; statistics still count that update.
- Reset: valid all 0; cnt all 2^(CNT_W-1)−1; tags, targets and uncond 0; statistics 0. Outputs after reset: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4.
- No other hidden state; no FSM beyond per-entry counters.

## Timing
- Lookup latency 0 cycles (pure combinational from lookup_pc and table state).
- Update visible to lookup the cycle after the upd_en edge. Same-cycle lookup/update to the same index returns pre-update state; there is no bypass.
- Statistics registered; they reflect an update one cycle after upd_en.
- rst asserted mid-operation takes effect immediately, regardless of clk. The first update is accepted at the first rising edge after rst deasserts.
- Combinational path lookup_pc→pred_target must fit within the IF stage alongside instruction fetch.

## Test plan
(ENTRIES=16, TAG_W=8, CNT_W=2.)
- Reset, lookup 0x0000_0040 → pred_hit=0, pred_taken=0, pred_target=0x0000_0044; both statistics 0.
- Update pc=0x40 taken, target=0x100, mispredict=1; next cycle lookup 0x40 → hit=1, taken=1, target=0x100; stat_branches=1, stat_mispredicts=1.
- Continue with three not-taken updates at 0x40 → cnt 2→1→0→0, pred_taken=0 from the first. Then one taken → cnt 1, still not taken. A second taken → cnt 2, taken, target 0x100.
- Alias: 0x40 entry present; update 0x80 (same index 0, tag 2) taken, target 0x200 → lookup 0x40 miss, target 0x44; lookup 0x80 hit, target 0x200.
- JAL: update pc=0x10, uncond=1, taken, target 0x300; then an upd_taken=0 update at 0x10 → lookup 0x10 still taken, target 0x300.
- clear and upd_en together, then async rst pulsed between edges:
  - After clear+upd_en: all lookups miss and stat_branches increments.
  - During the rst pulse: outputs and statistics drop to reset values immediately.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters for the RV32I pipeline.
// IF looks up combinationally; EX trains the tables and accumulates statistics.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_uncond,
  input  logic        upd_mispredict,
  input  logic        clear,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CMAX  = '1;
  localparam logic [CNT_W-1:0] CONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CWT   = CONE << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CINIT = CWT - CONE;

  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [31:0]      target_d [ENTRIES];
  logic             uncond_q [ENTRIES];
  logic             uncond_d [ENTRIES];
  logic [CNT_W-1:0] cnt_q    [ENTRIES];
  logic [CNT_W-1:0] cnt_d    [ENTRIES];
  logic [31:0]      br_q, br_d, mp_q, mp_d;

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             upd_hit;
  logic             unused_bits;

  assign unused_bits = ^{lookup_pc, upd_pc};

  assign lk_idx  = lookup_pc[IDX_W+1:2];
  assign lk_tag  = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  assign pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = pred_hit && (uncond_q[lk_idx] || cnt_q[lk_idx][CNT_W-1]);
  assign pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + 32'd4;

  assign stat_branches    = br_q;
  assign stat_mispredicts = mp_q;

  // A not-taken report against a JAL entry is ignored so jumps stay predicted taken.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    uncond_d = uncond_q;
    cnt_d    = cnt_q;
    if (clear) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_d[i] = 1'b0;
        cnt_d[i]   = CINIT;
      end
    end else if (upd_en) begin
      if (upd_hit) begin
        if (!(uncond_q[upd_idx] && !upd_taken)) begin
          uncond_d[upd_idx] = upd_uncond;
          if (upd_taken) target_d[upd_idx] = upd_target;
          if (upd_uncond) cnt_d[upd_idx] = CMAX;
          else if (upd_taken) begin
            if (cnt_q[upd_idx] != CMAX) cnt_d[upd_idx] = cnt_q[upd_idx] + CONE;
          end else if (cnt_q[upd_idx] != '0) begin
            cnt_d[upd_idx] = cnt_q[upd_idx] - CONE;
          end
        end
      end else if (upd_taken) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target;
        uncond_d[upd_idx] = upd_uncond;
        cnt_d[upd_idx]    = upd_uncond ? CMAX : CWT;
      end
    end
  end

  always_comb begin
    br_d = br_q;
    mp_d = mp_q;
    if (upd_en && (br_q != 32'hFFFF_FFFF)) br_d = br_q + 32'd1;
    if (upd_en && upd_mispredict && (mp_q != 32'hFFFF_FFFF)) mp_d = mp_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        uncond_q[i] <= 1'b0;
        cnt_q[i]    <= CINIT;
      end
      br_q <= '0;
      mp_q <= '0;
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      uncond_q <= uncond_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      mp_q     <= mp_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus randomized traffic
// checked against a table-of-entries reference model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] lookup_pc = '0;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_en = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_uncond = 1'b0;
  logic        upd_mispredict = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] stat_branches, stat_mispredicts;

  int nTests = 0;
  int nFail  = 0;

  // Reference model: one record per BTB slot, counter kept as a plain integer 0..3.
  bit          mValid  [16];
  int unsigned mTag    [16];
  logic [31:0] mTarget [16];
  bit          mUncond [16];
  int          mCnt    [16];
  longint      mBranches, mMispredicts;

  branch_predictor #(.ENTRIES(16), .TAG_W(8), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_uncond(upd_uncond), .upd_mispredict(upd_mispredict), .clear(clear),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nTests++;
    if (observed !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 16; i++) begin
      mValid[i] = 0; mTag[i] = 0; mTarget[i] = '0; mUncond[i] = 0; mCnt[i] = 1;
    end
    mBranches = 0;
    mMispredicts = 0;
  endfunction

  function automatic void modelUpdate(bit en, logic [31:0] pc, bit tk, logic [31:0] tgt, bit u, bit mp, bit clr);
    int i;
    int unsigned t;
    i = (pc / 4) % 16;
    t = (pc / 64) % 256;
    if (en) begin
      if (mBranches < 64'hFFFF_FFFF) mBranches++;
      if (mp && mMispredicts < 64'hFFFF_FFFF) mMispredicts++;
    end
    if (clr) begin
      for (int k = 0; k < 16; k++) begin
        mValid[k] = 0;
        mCnt[k] = 1;
      end
    end else if (en) begin
      if (mValid[i] && mTag[i] == t) begin
        if (mUncond[i] && !tk) return;
        mUncond[i] = u;
        if (tk) mTarget[i] = tgt;
        if (u) mCnt[i] = 3;
        else if (tk) mCnt[i] = (mCnt[i] + 1 > 3) ? 3 : mCnt[i] + 1;
        else mCnt[i] = (mCnt[i] - 1 < 0) ? 0 : mCnt[i] - 1;
      end else if (tk) begin
        mValid[i] = 1; mTag[i] = t; mTarget[i] = tgt; mUncond[i] = u;
        mCnt[i] = u ? 3 : 2;
      end
    end
  endfunction

  task automatic checkAgainstModel(input logic [31:0] lpc);
    int i;
    bit h, tk;
    i  = (lpc / 4) % 16;
    h  = mValid[i] && mTag[i] == (lpc / 64) % 256;
    tk = h && (mUncond[i] || mCnt[i] >= 2);
    checkOutput("model_hit", {31'd0, pred_hit}, {31'd0, h});
    checkOutput("model_taken", {31'd0, pred_taken}, {31'd0, tk});
    checkOutput("model_target", pred_target, tk ? mTarget[i] : lpc + 32'd4);
    checkOutput("model_branches", stat_branches, mBranches[31:0]);
    checkOutput("model_mispredicts", stat_mispredicts, mMispredicts[31:0]);
  endtask

  // One cycle: drive at negedge, check the pre-edge lookup, then let the edge train.
  task automatic applyStimulus(input bit en, input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                               input bit u, input bit mp, input bit clr, input logic [31:0] lpc);
    @(negedge clk);
    upd_en = en; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_uncond = u; upd_mispredict = mp; clear = clr; lookup_pc = lpc;
    #1;
    checkAgainstModel(lpc);
    @(posedge clk);
    modelUpdate(en, pc, tk, tgt, u, mp, clr);
  endtask

  task automatic probe(input string tag, input logic [31:0] lpc, input bit h, input bit tk, input logic [31:0] tgt);
    @(negedge clk);
    upd_en = 1'b0; clear = 1'b0; lookup_pc = lpc;
    #1;
    checkOutput({tag, "_hit"}, {31'd0, pred_hit}, {31'd0, h});
    checkOutput({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, tk});
    checkOutput({tag, "_target"}, pred_target, tgt);
  endtask

  initial begin
    logic [31:0] pc, lpc;
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    probe("reset", 32'h40, 0, 0, 32'h44);
    checkOutput("reset_branches", stat_branches, 32'd0);
    checkOutput("reset_mispredicts", stat_mispredicts, 32'd0);

    applyStimulus(1, 32'h40, 1, 32'h100, 0, 1, 0, 32'h40);
    probe("alloc", 32'h40, 1, 1, 32'h100);
    checkOutput("alloc_branches", stat_branches, 32'd1);
    checkOutput("alloc_mispredicts", stat_mispredicts, 32'd1);

    applyStimulus(1, 32'h40, 0, 32'h0, 0, 1, 0, 32'h40);
    probe("nt1", 32'h40, 1, 0, 32'h44);
    applyStimulus(1, 32'h40, 0, 32'h0, 0, 0, 0, 32'h40);
    applyStimulus(1, 32'h40, 0, 32'h0, 0, 0, 0, 32'h40);
    applyStimulus(1, 32'h40, 1, 32'h100, 0, 1, 0, 32'h40);
    probe("cnt1", 32'h40, 1, 0, 32'h44);
    applyStimulus(1, 32'h40, 1, 32'h100, 0, 1, 0, 32'h40);
    probe("cnt2", 32'h40, 1, 1, 32'h100);

    applyStimulus(1, 32'h80, 1, 32'h200, 0, 1, 0, 32'h80);
    probe("alias_old", 32'h40, 0, 0, 32'h44);
    probe("alias_new", 32'h80, 1, 1, 32'h200);

    applyStimulus(1, 32'h10, 1, 32'h300, 1, 1, 0, 32'h10);
    applyStimulus(1, 32'h10, 0, 32'h0, 0, 1, 0, 32'h10);
    probe("jal", 32'h10, 1, 1, 32'h300);

    applyStimulus(1, 32'h80, 1, 32'h400, 0, 0, 1, 32'h80);
    probe("clr_80", 32'h80, 0, 0, 32'h84);
    probe("clr_10", 32'h10, 0, 0, 32'h14);
    checkOutput("clr_branches", stat_branches, 32'd10);

    applyStimulus(1, 32'h40, 1, 32'h500, 0, 0, 0, 32'h40);
    probe("pre_rst", 32'h40, 1, 1, 32'h500);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_hit", {31'd0, pred_hit}, 32'd0);
    checkOutput("rst_target", pred_target, 32'h44);
    checkOutput("rst_branches", stat_branches, 32'd0);
    checkOutput("rst_mispredicts", stat_mispredicts, 32'd0);
    #1 rst = 1'b0;
    modelReset();
    applyStimulus(1, 32'h40, 1, 32'h600, 0, 0, 0, 32'h40);
    probe("post_rst", 32'h40, 1, 1, 32'h600);

    // Small tag/index pool so hits, aliases and counter saturation all occur often.
    for (int n = 0; n < 500; n++) begin
      bit en, tk, u, clr;
      pc  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      lpc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 9) == 0) pc = pc | 32'h4000_0000;
      en  = ($urandom_range(0, 3) != 0);
      u   = ($urandom_range(0, 7) == 0);
      tk  = u || $urandom_range(0, 1);
      clr = ($urandom_range(0, 39) == 0);
      applyStimulus(en, pc, tk, $urandom & 32'hFFFF_FFFC, u, $urandom_range(0, 1), clr, lpc);
    end
    probe("final", 32'h0, mValid[0] && mTag[0] == 0, mValid[0] && mTag[0] == 0 && (mUncond[0] || mCnt[0] >= 2),
          (mValid[0] && mTag[0] == 0 && (mUncond[0] || mCnt[0] >= 2)) ? mTarget[0] : 32'h4);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
